hid_report_scheduler: RTL and testbench
=======================================

Name: hid_report_scheduler

Overview:
- Sits between the mouse pattern generator, a manual/debug motion source and the USB SIE IN endpoint.
- Configures the generator through pat_enable and pat_sel, with optional automatic pattern cycling.
- Accumulates signed motion deltas from both sources with saturation.
- Answers host IN tokens: serialises a 3-byte boot-mouse report over a valid/ready byte stream when data is pending, or NAKs when nothing is pending.
- Keeps un-acknowledged motion so no movement is lost on a retry.

Parameters:
ACC_W, 12, signed accumulator width; saturation limit is ±(2^(ACC_W-1)-1).
PAT_DWELL, 256, number of ACKed reports before auto-cycle advances pat_sel.

Ports:
clk  in  1  clock, 48 MHz
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  block enable
auto_cycle  in  1  1 = cycle patterns automatically, 0 = use pat_sel_manual
pat_sel_manual  in  2  manual pattern select
pat_enable  out  1  enable to the generator
pat_sel  out  2  pattern select to the generator
pat_x  in  8  generator dx, signed
pat_y  in  8  generator dy, signed
pat_buttons  in  3  generator buttons
pat_valid  in  1  generator report strobe; data is valid the cycle after it
man_dx  in  8  manual dx, signed
man_dy  in  8  manual dy, signed
man_buttons  in  3  manual buttons
man_valid  in  1  manual sample strobe; data is valid the same cycle
in_token  in  1  host IN token pulse
tx_data  out  8  report byte
tx_valid  out  1  byte valid
tx_last  out  1  final byte of the report
tx_ready  in  1  SIE accepts the byte
tx_ack  in  1  host ACK pulse
tx_timeout  in  1  no-ACK pulse
nak  out  1  one-cycle NAK response
busy  out  1  FSM not in IDLE
ovf  out  1  sticky saturation flag

Behaviour:
- Reset values: every output 0; accumulators 0; button latches 0; last_sent_buttons 0; FSM in IDLE.
- Generator interface:
  - pat_enable is enable, registered.
  - auto_cycle=0: pat_sel is pat_sel_manual, registered (1-cycle latency).
  - auto_cycle=1: pat_sel increments mod 4 after every PAT_DWELL ACKed reports; the dwell counter clears when auto_cycle falls.
- Sampling:
  - pat_valid is delayed 1 cycle to pat_s; pat_x, pat_y and pat_buttons are sampled when pat_s=1.
  - man_* are sampled when man_valid=1.
  - The button latch for each source updates on its own sample. Current buttons = pat latch OR man latch.
- Accumulation (acc_x, acc_y, signed ACC_W):
  - next = acc − sent_on_ack + pat_delta + man_delta. All terms are sign-extended; every term present in a cycle is applied in that cycle.
  - The result saturates to ±(2^(ACC_W-1)-1). ovf sets on any saturation and clears only while enable=0.
  - enable=0: accumulators and button latches are held at 0 and samples are ignored.
- Pending condition: acc_x≠0, or acc_y≠0, or current buttons ≠ last_sent_buttons.
- FSM:
  - IDLE: on in_token, go to LOAD if pending and enable=1. Otherwise pulse nak on the next cycle and stay in IDLE.
  - LOAD (1 cycle):
    - sx = clamp(acc_x to −127..127), sy likewise.
    - sb = current buttons.
    - Go to SEND with idx=0.
  - SEND:
    - tx_valid=1.
    - tx_data: idx0 = {5'b0, sb}; idx1 = sx; idx2 = sy.
    - tx_last=1 only at idx2.
    - tx_data is stable while tx_ready=0.
    - idx advances on tx_valid&tx_ready. After the idx2 handshake, go to WAIT_ACK with tx_valid low the next cycle.
  - WAIT_ACK:
    - tx_ack: subtract sx and sy from the accumulators, set last_sent_buttons=sb, count a report for auto-cycle, go to IDLE.
    - tx_timeout: go to IDLE with accumulators untouched.
    - tx_ack and tx_timeout in the same cycle: ACK wins.
- in_token outside IDLE is ignored (no nak).
- enable falling mid-transaction: the current transaction completes normally, and the ACK subtraction is suppressed because the accumulators are already cleared.
- busy = (state ≠ IDLE).

Decomposition:
- Package hid_mouse_pkg:
  - FSM state enum (IDLE, LOAD, SEND, WAIT_ACK).
  - Report length constant (3).
  - Byte index constants.
  - Report clamp limit (127).
- One sub-module: sat_accumulator.
  - Signed ACC_W accumulator with two add inputs, one subtract input and an overflow output.
  - Instantiated once for X and once for Y.

Test Plan:
- Single sample: pat_valid with pat_x=5, pat_y=−3, then in_token → bytes 0x00, 0x05, 0xFD, tx_last on the third byte. tx_ack → acc=0. A further in_token → nak pulse.
- Clamp and residual: 30 pat samples of dx=+10 (acc_x=300).
  - Token and ack → dx byte 0x7F, residual 173.
  - Second report → 0x7F, residual 46.
  - Third report → 0x2E, then acc_x=0.
- Simultaneous sources: pat_s and man_valid in the same cycle with dx +5 and +3 → acc_x=8. A same-cycle ACK subtracting 8 plus a new +2 sample → acc_x=2.
- Timeout and retry:
  - Report with dx=4, then tx_timeout → acc_x stays 4.
  - A +2 sample arrives, then a retry token → dx byte 0x06.
- Backpressure: tx_ready held low 10 cycles at idx1 → tx_valid=1 and tx_data=sx stable throughout. Release → idx2 follows.
- Auto-cycle and saturation:
  - PAT_DWELL=2, auto_cycle=1 → pat_sel goes 0→1 after 2 ACKs and wraps to 0 after 8 ACKs.
  - 20 samples of +127 with no token → acc_x=2047, ovf=1. ovf clears when enable=0.

Source files
------------

// File: rtl/hid_mouse_pkg.sv
// hid_mouse_pkg: shared types and constants for the HID boot-mouse report scheduler
// Contents: FSM state enum, report length and byte indices, report clamp limit and clamp helper.
package hid_mouse_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_ACK} state_t;

    localparam int         REPORT_LEN = 3;
    localparam logic [1:0] IDX_BTN    = 2'd0;
    localparam logic [1:0] IDX_X      = 2'd1;
    localparam logic [1:0] IDX_LAST   = 2'(REPORT_LEN - 1);
    localparam int         CLAMP      = 127;

    // Boot-mouse deltas are 8-bit signed but -128 is avoided so the report is symmetric.
    function automatic logic [7:0] clamp_report(input int v);
        return v > CLAMP ? 8'(CLAMP) : (v < -CLAMP ? 8'(-CLAMP) : 8'(v));
    endfunction

endpackage

// File: rtl/sat_accumulator.sv
// sat_accumulator: signed saturating accumulator with two addends and one subtrahend
// Ports: clk, rst_n (async active-low), clr (hold at zero), a_en/a and b_en/b (8-bit signed addends),
//        sub_en/sub (8-bit signed subtrahend), acc (W-bit signed total), sat (this cycle's result clipped).
module sat_accumulator #(
    parameter int W = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                a_en,
    input  logic signed [7:0]   a,
    input  logic                b_en,
    input  logic signed [7:0]   b,
    input  logic                sub_en,
    input  logic signed [7:0]   sub,
    output logic signed [W-1:0] acc,
    output logic                sat
);

    // Two guard bits cover |acc| + three 8-bit terms without wrapping.
    localparam logic signed [W+1:0] MAXV = (W+2)'(2 ** (W - 1) - 1);

    logic signed [W+1:0] ta, tb, ts, sum;
    logic signed [W-1:0] nxt;

    always_comb begin
        ta  = a_en ? (W+2)'(a) : '0;
        tb  = b_en ? (W+2)'(b) : '0;
        ts  = sub_en ? (W+2)'(sub) : '0;
        sum = (W+2)'(acc) - ts + ta + tb;
        sat = (sum > MAXV) || (sum < -MAXV);
        nxt = sum > MAXV ? MAXV[W-1:0] : (sum < -MAXV ? -MAXV[W-1:0] : sum[W-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else
            acc <= clr ? '0 : nxt;
    end

endmodule

// File: rtl/hid_report_scheduler.sv
// hid_report_scheduler: accumulates mouse motion from pattern and manual sources and serves 3-byte boot reports on IN tokens
// Ports: generator control (enable, auto_cycle, pat_sel_manual -> pat_enable, pat_sel),
//        generator input (pat_x/y/buttons, pat_valid; data valid one cycle after the strobe),
//        manual input (man_dx/dy/buttons, man_valid), SIE side (in_token, tx_data/valid/last, tx_ready,
//        tx_ack, tx_timeout, nak), status (busy, ovf).
module hid_report_scheduler
    import hid_mouse_pkg::*;
#(
    parameter int ACC_W     = 12,
    parameter int PAT_DWELL = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       auto_cycle,
    input  logic [1:0] pat_sel_manual,
    output logic       pat_enable,
    output logic [1:0] pat_sel,
    input  logic [7:0] pat_x,
    input  logic [7:0] pat_y,
    input  logic [2:0] pat_buttons,
    input  logic       pat_valid,
    input  logic [7:0] man_dx,
    input  logic [7:0] man_dy,
    input  logic [2:0] man_buttons,
    input  logic       man_valid,
    input  logic       in_token,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_last,
    input  logic       tx_ready,
    input  logic       tx_ack,
    input  logic       tx_timeout,
    output logic       nak,
    output logic       busy,
    output logic       ovf
);

    localparam int DW = $clog2(PAT_DWELL + 1);

    state_t                   state;
    logic [1:0]               idx;
    logic [7:0]               sx, sy;
    logic [2:0]               sb, pat_btn, man_btn, last_btn, cur_btn;
    logic [DW-1:0]            dwell;
    logic                     pat_s, pat_take, man_take, ack_evt, pending, sat_x, sat_y;
    logic signed [ACC_W-1:0]  acc_x, acc_y;

    assign pat_take = enable && pat_s;
    assign man_take = enable && man_valid;
    assign ack_evt  = (state == WAIT_ACK) && tx_ack;
    assign cur_btn  = pat_btn | man_btn;
    assign pending  = (acc_x != '0) || (acc_y != '0) || (cur_btn != last_btn);
    assign busy     = state != IDLE;

    // While disabled the accumulators are held cleared, so an ACK that lands then has nothing to subtract.
    sat_accumulator #(.W(ACC_W)) u_acc_x (
        .clk(clk), .rst_n(rst_n), .clr(!enable),
        .a_en(pat_take), .a(pat_x), .b_en(man_take), .b(man_dx),
        .sub_en(ack_evt), .sub(sx), .acc(acc_x), .sat(sat_x)
    );

    sat_accumulator #(.W(ACC_W)) u_acc_y (
        .clk(clk), .rst_n(rst_n), .clr(!enable),
        .a_en(pat_take), .a(pat_y), .b_en(man_take), .b(man_dy),
        .sub_en(ack_evt), .sub(sy), .acc(acc_y), .sat(sat_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_enable <= 1'b0;
            pat_sel    <= '0;
            dwell      <= '0;
            pat_s      <= 1'b0;
            pat_btn    <= '0;
            man_btn    <= '0;
            ovf        <= 1'b0;
        end else begin
            pat_enable <= enable;
            pat_s      <= pat_valid;
            if (!auto_cycle) begin
                pat_sel <= pat_sel_manual;
                dwell   <= '0;
            end else if (ack_evt) begin
                dwell   <= dwell == DW'(PAT_DWELL - 1) ? '0 : dwell + DW'(1);
                pat_sel <= dwell == DW'(PAT_DWELL - 1) ? pat_sel + 2'd1 : pat_sel;
            end
            pat_btn <= !enable ? '0 : (pat_take ? pat_buttons : pat_btn);
            man_btn <= !enable ? '0 : (man_take ? man_buttons : man_btn);
            ovf     <= enable && (ovf || sat_x || sat_y);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            sx       <= '0;
            sy       <= '0;
            sb       <= '0;
            last_btn <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            nak      <= 1'b0;
        end else begin
            nak <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_token && pending && enable)
                        state <= LOAD;
                    else if (in_token)
                        nak <= 1'b1;
                end
                LOAD: begin
                    sx       <= clamp_report(int'(acc_x));
                    sy       <= clamp_report(int'(acc_y));
                    sb       <= cur_btn;
                    tx_data  <= {5'b0, cur_btn};
                    tx_valid <= 1'b1;
                    tx_last  <= 1'b0;
                    idx      <= IDX_BTN;
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_ready && idx == IDX_LAST) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        state    <= WAIT_ACK;
                    end else if (tx_ready) begin
                        idx     <= idx + 2'd1;
                        tx_data <= idx == IDX_BTN ? sx : sy;
                        tx_last <= idx == IDX_X;
                    end
                end
                WAIT_ACK: begin
                    if (tx_ack) begin
                        last_btn <= sb;
                        state    <= IDLE;
                    end else if (tx_timeout) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hid_report_scheduler.sv
// tb_hid_report_scheduler: directed self-checking bench for hid_report_scheduler
module tb_hid_report_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0, auto_cycle = 1'b0;
    logic [1:0] pat_sel_manual = '0;
    logic       pat_enable;
    logic [1:0] pat_sel;
    logic [7:0] pat_x = '0, pat_y = '0, man_dx = '0, man_dy = '0;
    logic [2:0] pat_buttons = '0, man_buttons = '0;
    logic       pat_valid = 1'b0, man_valid = 1'b0, in_token = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid, tx_last, nak, busy, ovf;
    logic       tx_ready = 1'b0, tx_ack = 1'b0, tx_timeout = 1'b0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    hid_report_scheduler #(.ACC_W(12), .PAT_DWELL(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .auto_cycle(auto_cycle),
        .pat_sel_manual(pat_sel_manual), .pat_enable(pat_enable), .pat_sel(pat_sel),
        .pat_x(pat_x), .pat_y(pat_y), .pat_buttons(pat_buttons), .pat_valid(pat_valid),
        .man_dx(man_dx), .man_dy(man_dy), .man_buttons(man_buttons), .man_valid(man_valid),
        .in_token(in_token), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .tx_ack(tx_ack), .tx_timeout(tx_timeout),
        .nak(nak), .busy(busy), .ovf(ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pat_sample(input logic [7:0] dx, input logic [7:0] dy, input logic [2:0] b);
        pat_valid = 1'b1;
        tick();
        pat_valid = 1'b0;
        pat_x = dx; pat_y = dy; pat_buttons = b;
        tick();
    endtask

    task automatic man_sample(input logic [7:0] dx, input logic [7:0] dy, input logic [2:0] b);
        man_valid = 1'b1;
        man_dx = dx; man_dy = dy; man_buttons = b;
        tick();
        man_valid = 1'b0;
    endtask

    task automatic get_report(output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] b2,
                              output logic last_ok);
        logic [7:0] b [3];
        int n;
        last_ok  = 1'b1;
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!tx_valid && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (tx_valid !== 1'b1) begin
                fails++;
                $display("FAIL report_wait: tx_valid=%b for byte %0d, required 1", tx_valid, k);
            end
            b[k] = tx_data;
            if (tx_last !== (k == 2)) last_ok = 1'b0;
            tick();
        end
        tx_ready = 1'b0;
        b0 = b[0]; b1 = b[1]; b2 = b[2];
    endtask

    task automatic ack();
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        repeat (3) tick();
        checks++;
        if ({pat_enable, pat_sel, tx_data, tx_valid, tx_last, nak, busy, ovf} !== 16'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0000",
                     {pat_enable, pat_sel, tx_data, tx_valid, tx_last, nak, busy, ovf});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (pat_enable !== 1'b1) begin fails++; $display("FAIL pat_enable: got %b, required 1", pat_enable); end
    endtask

    task automatic test_single();
        logic [7:0] b0, b1, b2;
        logic lo;
        pat_sample(8'd5, 8'hFD, 3'd0);
        get_report(b0, b1, b2, lo);
        checks++;
        if ({b0, b1, b2} !== 24'h0005FD) begin fails++; $display("FAIL single_bytes: got %h, required 0005fd", {b0, b1, b2}); end
        checks++;
        if (lo !== 1'b1) begin fails++; $display("FAIL single_last: tx_last pattern wrong, got ok=%b, required 1", lo); end
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL wait_ack_busy: got %b, required 1", busy); end
        ack();
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b, required 0", busy); end
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        checks++;
        if (nak !== 1'b1) begin fails++; $display("FAIL nak_pulse: got %b, required 1", nak); end
        tick();
        checks++;
        if (nak !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL nak_end: nak=%b busy=%b, required 0 0", nak, busy); end
    endtask

    task automatic test_clamp();
        logic [7:0] b0, b1, b2;
        logic lo;
        logic [7:0] exp_x [3];
        exp_x[0] = 8'h7F; exp_x[1] = 8'h7F; exp_x[2] = 8'h2E;
        for (int i = 0; i < 30; i++) pat_sample(8'd10, 8'd0, 3'd0);
        for (int r = 0; r < 3; r++) begin
            get_report(b0, b1, b2, lo);
            checks++;
            if ({b0, b1, b2, lo} !== {8'h00, exp_x[r], 8'h00, 1'b1}) begin
                fails++;
                $display("FAIL clamp_report%0d: got %h %h %h last_ok=%b, required 00 %h 00 1", r, b0, b1, b2, lo, exp_x[r]);
            end
            ack();
        end
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        checks++;
        if (nak !== 1'b1) begin fails++; $display("FAIL clamp_drained_nak: got %b, required 1", nak); end
        tick();
    endtask

    task automatic test_simultaneous();
        logic [7:0] b0, b1, b2;
        logic lo;
        pat_valid = 1'b1;
        tick();
        pat_valid = 1'b0;
        pat_x = 8'd5; pat_y = 8'd0;
        man_valid = 1'b1; man_dx = 8'd3; man_dy = 8'd0; man_buttons = 3'd0;
        tick();
        man_valid = 1'b0;
        get_report(b0, b1, b2, lo);
        checks++;
        if (b1 !== 8'h08) begin fails++; $display("FAIL simul_sum: got %h, required 08", b1); end
        tx_ack = 1'b1; man_valid = 1'b1; man_dx = 8'd2;
        tick();
        tx_ack = 1'b0; man_valid = 1'b0;
        get_report(b0, b1, b2, lo);
        checks++;
        if (b1 !== 8'h02) begin fails++; $display("FAIL simul_ack_and_sample: got %h, required 02", b1); end
        ack();
    endtask

    task automatic test_buttons();
        logic [7:0] b0, b1, b2;
        logic lo;
        man_sample(8'd0, 8'd0, 3'b101);
        get_report(b0, b1, b2, lo);
        checks++;
        if ({b0, b1, b2} !== 24'h050000) begin fails++; $display("FAIL buttons_press: got %h, required 050000", {b0, b1, b2}); end
        ack();
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        checks++;
        if (nak !== 1'b1) begin fails++; $display("FAIL buttons_unchanged_nak: got %b, required 1", nak); end
        tick();
        man_sample(8'd0, 8'd0, 3'b000);
        get_report(b0, b1, b2, lo);
        checks++;
        if ({b0, b1, b2} !== 24'h000000 || busy !== 1'b1) begin
            fails++;
            $display("FAIL buttons_release: got %h busy=%b, required 000000 busy=1", {b0, b1, b2}, busy);
        end
        ack();
    endtask

    task automatic test_timeout();
        logic [7:0] b0, b1, b2;
        logic lo;
        pat_sample(8'd4, 8'd0, 3'd0);
        get_report(b0, b1, b2, lo);
        checks++;
        if (b1 !== 8'h04) begin fails++; $display("FAIL timeout_first: got %h, required 04", b1); end
        tx_timeout = 1'b1;
        tick();
        tx_timeout = 1'b0;
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL timeout_idle: busy=%b, required 0", busy); end
        pat_sample(8'd2, 8'd0, 3'd0);
        get_report(b0, b1, b2, lo);
        checks++;
        if (b1 !== 8'h06) begin fails++; $display("FAIL timeout_retry: got %h, required 06", b1); end
        ack();
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        pat_sample(8'd9, 8'd0, 3'd0);
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        tx_ready = 1'b1;
        n = 0;
        while (!tx_valid && n < 20) begin tick(); n++; end
        tick();
        tx_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_token = (i == 3);
            tick();
            if (tx_valid !== 1'b1 || tx_data !== 8'h09 || tx_last !== 1'b0 || nak !== 1'b0) bad++;
        end
        in_token = 1'b0;
        checks++;
        if (bad != 0) begin fails++; $display("FAIL stall_hold: %0d bad cycles, required 0", bad); end
        tx_ready = 1'b1;
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h00 || tx_last !== 1'b1) begin
            fails++;
            $display("FAIL stall_release: valid=%b data=%h last=%b, required 1 00 1", tx_valid, tx_data, tx_last);
        end
        tick();
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL stall_done: valid=%b busy=%b, required 0 1", tx_valid, busy);
        end
        ack();
    endtask

    task automatic test_auto_cycle();
        logic [7:0] b0, b1, b2;
        logic lo;
        logic [1:0] exp;
        auto_cycle = 1'b1;
        tick();
        for (int r = 1; r <= 8; r++) begin
            pat_sample(8'd1, 8'd0, 3'd0);
            get_report(b0, b1, b2, lo);
            ack();
            exp = 2'((r / 2) % 4);
            checks++;
            if (pat_sel !== exp) begin fails++; $display("FAIL auto_sel_after_%0d: got %0d, required %0d", r, pat_sel, exp); end
        end
        auto_cycle = 1'b0;
        pat_sel_manual = 2'd2;
        tick();
        checks++;
        if (pat_sel !== 2'd2) begin fails++; $display("FAIL manual_sel: got %0d, required 2", pat_sel); end
    endtask

    task automatic test_saturation();
        checks++;
        if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear_before: got %b, required 0", ovf); end
        for (int i = 0; i < 20; i++) pat_sample(8'd127, 8'd0, 3'd0);
        checks++;
        if (dut.acc_x !== 12'sd2047 || ovf !== 1'b1) begin
            fails++;
            $display("FAIL saturate: acc_x=%0d ovf=%b, required 2047 1", dut.acc_x, ovf);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (ovf !== 1'b0 || pat_enable !== 1'b0 || dut.acc_x !== 12'sd0) begin
            fails++;
            $display("FAIL disable: ovf=%b pat_enable=%b acc_x=%0d, required 0 0 0", ovf, pat_enable, dut.acc_x);
        end
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        checks++;
        if (nak !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL disabled_nak: nak=%b busy=%b, required 1 0", nak, busy); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_clamp();
        test_simultaneous();
        test_buttons();
        test_timeout();
        test_backpressure();
        test_auto_cycle();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
